// File: rtl/ctrl_seq.sv
// Micro-step sequencer and opcode decoder for the 8-bit CPU.
// It produces one control word per clock from the step counter, the opcode and the ALU flags.
module ctrl_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en,
  input  logic [3:0] ir_op_4,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halt,
  output logic [2:0] step_3
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_0 = 3'd0,
    ST_1 = 3'd1,
    ST_2 = 3'd2,
    ST_3 = 3'd3,
    ST_4 = 3'd4
  } step_e;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_in;
  } ctrl_t;

  step_e step_q, step_d;
  logic  halted_q, halted_d;
  ctrl_t ctrl;
  logic  advance;

  assign advance = step_en && !halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= ST_0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ctrl     = '0;
    step_d   = ST_0;
    halted_d = halted_q;
    case (step_q)
      ST_0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        step_d      = ST_1;
      end
      ST_1: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
        step_d       = ST_2;
      end
      ST_2: begin
        case (ir_op_4)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
            step_d      = ST_3;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_in   = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = flag_c;
          end
          OP_JZ: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = flag_z;
          end
          OP_OUT: begin
            ctrl.a_out  = 1'b1;
            ctrl.out_in = 1'b1;
          end
          OP_HLT: begin
            halted_d = 1'b1;
            step_d   = ST_2;
          end
          default: ;
        endcase
      end
      ST_3: begin
        case (ir_op_4)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.a_in    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
            step_d       = ST_4;
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_4: begin
        ctrl.alu_out  = 1'b1;
        ctrl.a_in     = 1'b1;
        ctrl.flags_in = 1'b1;
        ctrl.alu_sub  = (ir_op_4 == OP_SUB);
      end
      default: ;
    endcase
    // A stalled or halted sequencer keeps its state exactly as it is.
    if (!advance) begin
      step_d   = step_q;
      halted_d = halted_q;
    end
  end

  assign {pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
          a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in}
         = (rst_n && advance) ? ctrl : '0;
  assign halt   = rst_n && halted_q;
  assign step_3 = step_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed-vector bench for ctrl_seq: walks each opcode through its micro-steps and
// checks the full control word and step counter at every cycle.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n, step_en, flag_c, flag_z;
  logic [3:0] ir_op_4;
  logic       pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out;
  logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt;
  logic [2:0] step_3;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [15:0] PC_OUT   = 16'h8000;
  localparam logic [15:0] PC_INC   = 16'h4000;
  localparam logic [15:0] PC_LOAD  = 16'h2000;
  localparam logic [15:0] MAR_IN   = 16'h1000;
  localparam logic [15:0] RAM_IN   = 16'h0800;
  localparam logic [15:0] RAM_OUT  = 16'h0400;
  localparam logic [15:0] IR_IN    = 16'h0200;
  localparam logic [15:0] IR_OUT   = 16'h0100;
  localparam logic [15:0] A_IN     = 16'h0080;
  localparam logic [15:0] A_OUT    = 16'h0040;
  localparam logic [15:0] B_IN     = 16'h0020;
  localparam logic [15:0] ALU_OUT  = 16'h0010;
  localparam logic [15:0] ALU_SUB  = 16'h0008;
  localparam logic [15:0] FLAGS_IN = 16'h0004;
  localparam logic [15:0] OUT_IN   = 16'h0002;
  localparam logic [15:0] HALT     = 16'h0001;

  ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .ir_op_4(ir_op_4),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
    .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
    .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in), .halt(halt),
    .step_3(step_3)
  );

  always #5 clk = ~clk;

  logic [15:0] word;
  assign word = {pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
                 a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt};

  task automatic chk(input string tag, input logic [15:0] ew, input logic [2:0] es);
    #1;
    vectors++;
    assert ({word, step_3} === {ew, es}) else begin
      miscompares++;
      $error("FAIL %s: got word=%h step=%0d, expected word=%h step=%0d",
             tag, word, step_3, ew, es);
    end
    $display("vec %0d %s word=%h step=%0d", vectors, tag, word, step_3);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_step(input string tag, input logic [15:0] ew, input logic [2:0] es);
    chk(tag, ew, es);
    tick();
  endtask

  // Steps 0 and 1; the opcode is scrambled during step 0 to show it is ignored there.
  task automatic fetch(input logic [3:0] op);
    ir_op_4 = ~op;
    run_step("fetch0", PC_OUT | MAR_IN, 3'd0);
    ir_op_4 = op;
    run_step("fetch1", RAM_OUT | IR_IN | PC_INC, 3'd1);
  endtask

  initial begin
    rst_n = 1'b0; step_en = 1'b0; ir_op_4 = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    #3;
    chk("reset", 16'h0000, 3'd0);
    step_en = 1'b1;
    tick();
    chk("reset_en", 16'h0000, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fetch(4'b0000);
    run_step("lda2", IR_OUT | MAR_IN, 3'd2);
    run_step("lda3", RAM_OUT | A_IN, 3'd3);

    fetch(4'b0001);
    run_step("add2", IR_OUT | MAR_IN, 3'd2);
    run_step("add3", RAM_OUT | B_IN, 3'd3);
    run_step("add4", ALU_OUT | A_IN | FLAGS_IN, 3'd4);

    fetch(4'b0010);
    run_step("sub2", IR_OUT | MAR_IN, 3'd2);
    run_step("sub3", RAM_OUT | B_IN, 3'd3);
    run_step("sub4", ALU_OUT | A_IN | FLAGS_IN | ALU_SUB, 3'd4);

    flag_c = 1'b0; flag_z = 1'b1;
    fetch(4'b0111);
    run_step("jc_c0", IR_OUT, 3'd2);
    flag_c = 1'b1; flag_z = 1'b0;
    fetch(4'b0111);
    run_step("jc_c1", IR_OUT | PC_LOAD, 3'd2);
    fetch(4'b1000);
    run_step("jz_z0", IR_OUT, 3'd2);
    flag_c = 1'b0; flag_z = 1'b1;
    fetch(4'b1000);
    run_step("jz_z1", IR_OUT | PC_LOAD, 3'd2);
    flag_z = 1'b0;

    fetch(4'b0110);
    run_step("jmp2", IR_OUT | PC_LOAD, 3'd2);
    fetch(4'b0101);
    run_step("ldi2", IR_OUT | A_IN, 3'd2);
    fetch(4'b1110);
    run_step("out2", A_OUT | OUT_IN, 3'd2);

    fetch(4'b0100);
    run_step("sta2", IR_OUT | MAR_IN, 3'd2);
    step_en = 1'b0;
    for (int i = 0; i < 4; i++) run_step("sta_stall", 16'h0000, 3'd3);
    step_en = 1'b1;
    run_step("sta3", A_OUT | RAM_IN, 3'd3);

    fetch(4'b1010);
    run_step("nop2", 16'h0000, 3'd2);

    run_step("rst_f0", PC_OUT | MAR_IN, 3'd0);
    chk("rst_f1", RAM_OUT | IR_IN | PC_INC, 3'd1);
    rst_n = 1'b0;
    chk("rst_mid", 16'h0000, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fetch(4'b1111);
    run_step("hlt2", 16'h0000, 3'd2);
    for (int i = 0; i < 20; i++) run_step("halted", HALT, 3'd2);
    step_en = 1'b0;
    run_step("halted_noen", HALT, 3'd2);
    step_en = 1'b1;
    chk("halted_pre_rst", HALT, 3'd2);
    rst_n = 1'b0;
    chk("halt_rst", 16'h0000, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst", PC_OUT | MAR_IN, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Control sequencer for the 8-bit CPU: a 5-step micro-step counter plus opcode decoder that drives every bus enable and load strobe, including `ram_in`/`ram_out` on the 16x8 RAM and `mar_in`, which latches the 4-bit RAM address. It sits directly upstream of the RAM and the other datapath registers. It consumes the instruction register's opcode nibble and the ALU flags. The block produces one control word per clock and no datapath signals.

## Interface
- No parameters.
- `clk`  in  1  system clock; all datapath registers and RAM capture on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `step_en`  in  1  run enable; 0 freezes the sequencer and suppresses all strobes (single-step support).
- `ir_op_4`  in  4  opcode, which is the IR upper nibble.
- `flag_c`, `flag_z`  in  1 each  carry and zero flags from the flags register.
- `pc_out`, `pc_inc`, `pc_load`  out  1 each  PC drives bus / PC increments / PC loads from bus.
- `mar_in`  out  1  MAR loads the bus low nibble, which becomes the RAM address.
- `ram_in`, `ram_out`  out  1 each  RAM write from bus / RAM drives bus.
- `ir_in`, `ir_out`  out  1 each  IR loads from bus / IR drives its low nibble onto the bus.
- `a_in`, `a_out`, `b_in`  out  1 each  A load, A drive, B load.
- `alu_out`, `alu_sub`, `flags_in`  out  1 each  ALU drives bus, subtract select, flags register load.
- `out_in`  out  1  output register load.
- `halt`  out  1  sequencer halted.
- `step_3`  out  3  current micro-step, 0..4, for debug.

## Operation
- State registers: `step` (3 bits, 0..4) and `halted` (1 bit). The only registers in the block.
- All control outputs are combinational from `step`, `ir_op_4`, flags, `halted`, `step_en` and `rst_n`.
- At most one bus driver is asserted at any step.
- Fetch, identical for every opcode:
  - step 0: `pc_out`, `mar_in`.
  - step 1: `ram_out`, `ir_in`, `pc_inc`.
- Execute, by opcode. "End" means the next step is 0.
  - 0000 LDA: step 2 `ir_out`,`mar_in`; step 3 `ram_out`,`a_in`; end.
  - 0001 ADD: step 2 `ir_out`,`mar_in`; step 3 `ram_out`,`b_in`; step 4 `alu_out`,`a_in`,`flags_in`; end.
  - 0010 SUB: same as ADD, with `alu_sub`=1 on step 4 only.
  - 0100 STA: step 2 `ir_out`,`mar_in`; step 3 `a_out`,`ram_in`; end.
  - 0101 LDI: step 2 `ir_out`,`a_in`; end.
  - 0110 JMP: step 2 `ir_out`,`pc_load`; end.
  - 0111 JC: step 2 `ir_out`; `pc_load` only if `flag_c`=1; end.
  - 1000 JZ: step 2 `ir_out`; `pc_load` only if `flag_z`=1; end.
  - 1110 OUT: step 2 `a_out`,`out_in`; end.
  - 1111 HLT: step 2 sets `halted`; no other strobes.
  - All other opcodes are NOP: step 2 asserts nothing; end.
- Halted state:
  - `halt`=1 and all other control outputs are 0.
  - `step` holds at 2. Only reset leaves the state.
- `step_en`=0:
  - `step` and `halted` hold.
  - Every control output except `halt` is forced to 0, so no RAM write or bus drive occurs.
- `rst_n`=0 forces all control outputs to 0 regardless of `step`.

## Timing
- Reset (async assert): `step`=0, `halted`=0, every output 0, `step_3`=0.
- After reset release, the first active rising edge finds step 0 decoded.
- `step` advances on `clk` rising edge when `step_en`=1 and `halted`=0.
  - Non-final step: `step`+1.
  - Final step of the instruction: 0.
  - Step 4 is always final.
- Strobes are stable for the whole cycle of their step. Target registers and RAM capture at the rising edge that ends that step.
- Flags and `ir_op_4` are sampled combinationally during the step that uses them.
  - The opcode is valid from step 2 onward, because IR loads at the end of step 1.
  - `ir_op_4` during steps 0-1 is ignored.
- Cycles per instruction, excluding `step_en` stalls:
  - LDA/STA: 4.
  - ADD/SUB: 5.
  - LDI/JMP/JC/JZ/OUT/NOP: 3.
  - HLT: `halt` rises at the end of step 2.
- Reset asserted mid-instruction aborts it immediately; no partial strobe persists.
- `step_en` dropping mid-instruction resumes at the same step with identical strobes.

## Test plan
- Reset, then `step_en`=1, `ir_op_4`=0000 loaded at step 1 -> steps 0,1,2,3,0. Strobes at step 3 are exactly `ram_out`+`a_in`. `step_3` sequence is 0,1,2,3,0.
- ADD then SUB -> 5 steps each. `alu_sub`=0 on ADD step 4 and 1 on SUB step 4. `flags_in` is high only on step 4.
- JC with `flag_c`=0, then with `flag_c`=1 -> `pc_load` is 0 and then 1 at step 2. Both return to step 0 after 3 cycles.
- STA with `step_en` pulled low at step 3 for 4 cycles -> `ram_in`=0 throughout the stall. `ram_in`=1 for exactly one cycle after resume, then step 0.
- HLT -> `halt`=1 from the cycle after step 2. All strobes stay 0 for 20 further cycles with `step_en`=1. Asserting `rst_n`=0 clears `halt` asynchronously and sets `step_3`=0.
- Opcode 1010 (NOP) -> 3-cycle instruction with no strobes at step 2. Reset asserted during step 1 clears all outputs within the same cycle.
